lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit between the execute stage and `Data_memory`. It accepts one RV32I load or store per handshake and decodes `funct3` into the memory's `load_type`/`store_type` encodings. It checks natural alignment, drives a single-cycle memory access, then sign- or zero-extends the returned byte, half or word. The result goes back to writeback through a valid/ready response channel.

## Interface
- `XLEN`, 32: data and address width.
- `clk`  in  1: core clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I load/store funct3.
- `req_addr`  in  32: effective byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `req_rd`  in  5: load destination register.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: writeback accepts the response.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_rd`  out  5: echoed `req_rd`; 0 for stores and errors.
- `resp_err`  out  2: 00 ok, 01 misaligned, 10 illegal funct3.
- `mem_memwrite`  out  1: memory write strobe.
- `mem_addr`  out  32: memory address.
- `mem_load_type`  out  2: 00 word, 01 half, 10 byte.
- `mem_store_type`  out  2: 00 word, 01 half, 10 byte.
- `mem_wdata`  out  32: store data, right-aligned.
- `mem_rdata_word`, `mem_rdata_half`, `mem_rdata_byte`  in  32/16/8: memory read data. Reads are combinational, valid in the same cycle the address is presented.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Request handling:
  - `req_ready` = 1 only in IDLE.
  - A request is accepted on a clock edge with `req_valid & req_ready`.
  - On acceptance, all request fields are registered and decoded.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All other codes are illegal.
  - Stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Alignment:
  - Half accesses need `addr[0]` = 0.
  - Word accesses need `addr[1:0]` = 0.
  - Byte accesses are always aligned.
- Error priority: illegal outranks misaligned.
- Transitions:
  - IDLE→ACCESS on an accepted legal, aligned request.
  - IDLE→RESP on an accepted request that is illegal or misaligned. No memory access is made and `mem_memwrite` never rises.
  - ACCESS→RESP unconditionally. The load result is captured at the end of ACCESS.
  - RESP→IDLE on `resp_ready` = 1.
- Memory-side outputs during ACCESS:
  - `mem_addr`, `mem_load_type`, `mem_store_type` and `mem_wdata` are driven from the registered request.
  - `mem_memwrite` = 1 for exactly that one cycle, and only for stores.
  - Outside ACCESS, `mem_memwrite` = 0 and the other memory-side outputs hold their last value.
- Load extension:
  - LB sign-extends bit 7 of `mem_rdata_byte`; LBU zero-extends it.
  - LH sign-extends bit 15 of `mem_rdata_half`; LHU zero-extends it.
  - LW passes `mem_rdata_word` through.
- Store response: `resp_err` = 00, `resp_rdata` = 0, `resp_rd` = 0.
- Reset values: state IDLE; all outputs 0. `req_ready` reads 1 once reset is released.
- Reset mid-operation: the FSM returns to IDLE asynchronously and `mem_memwrite` drops immediately. The pending response is discarded.

## Timing
- Request accepted at edge N.
- ACCESS occupies cycle N→N+1. The memory write lands at edge N+1.
- `resp_valid` rises after edge N+1.
- Error responses appear after edge N, a latency of 1.
- Response channel:
  - `resp_*` stays stable while `resp_valid & !resp_ready`.
  - `resp_valid` falls on the edge where `resp_ready` = 1.
  - The next request can be accepted one cycle later, once back in IDLE.
- Throughput: one access per 3 cycles with `resp_ready` tied high.
- `req_*` is ignored outside IDLE.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants.
  - `mem_size_e` (WORD = 2'b00, HALF = 2'b01, BYTE = 2'b10).
  - `lsu_state_e` (IDLE, ACCESS, RESP).
  - `lsu_err_e` (OK, MISALIGN, ILLEGAL).
- Sub-module `lsu_extend`: combinational unit that takes funct3 and the three read buses and produces the 32-bit extended load value.

## Test plan
- SW `0xDEADBEEF` @`0x4`, then LW @`0x4` → `mem_memwrite` high exactly 1 cycle with store_type 00; load returns `resp_rdata` = `0xDEADBEEF`, `resp_err` 00, `resp_rd` echoed.
- After the SW, LB @`0x7` → `0xFFFFFFDE`; LBU @`0x7` → `0x000000DE`; LH @`0x6` → `0xFFFFDEAD`; LHU @`0x6` → `0x0000DEAD`.
- SH `0xABCD` @`0x6`, then LW @`0x4` → `0xABCDBEEF`. SB `0xEF` @`0x7`, then LW @`0x4` → `0xEFCDBEEF`.
- LH @`0x5`, SW @`0x6`, load funct3 `011` → `resp_err` 01, 01, 10 respectively; response after 1 cycle; `mem_memwrite` stays 0; memory is unchanged.
- Hold `resp_ready` = 0 for 3 cycles on an LW → `resp_*` stable, `req_ready` = 0, and a concurrent `req_valid` is not accepted.
- Assert `resetn` = 0 mid-cycle in ACCESS of a SW → `mem_memwrite` drops immediately; after release the state is IDLE, `resp_valid` = 0 and `req_ready` = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store control unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {WORD = 2'b00, HALF = 2'b01, BYTE = 2'b10} mem_size_e;
    typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} lsu_state_e;
    typedef enum logic [1:0] {OK = 2'b00, MISALIGN = 2'b01, ILLEGAL = 2'b10} lsu_err_e;

    function automatic mem_size_e f3_size(input logic [2:0] f3);
        mem_size_e s;
        case (f3[1:0])
            2'b00:   s = BYTE;
            2'b01:   s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input mem_size_e s, input logic [1:0] a);
        logic bad;
        case (s)
            HALF:    bad = a[0];
            WORD:    bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the memory read buses according to the load funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata_word,
    input  logic [15:0] i_rdata_half,
    input  logic [7:0]  i_rdata_byte,
    output logic [31:0] o_rdata
);

    // Select and extend the bus matching the access size
    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_rdata = {{24{i_rdata_byte[7]}}, i_rdata_byte};
            F3_BU:   o_rdata = {24'h00_0000, i_rdata_byte};
            F3_H:    o_rdata = {{16{i_rdata_half[15]}}, i_rdata_half};
            F3_HU:   o_rdata = {16'h0000, i_rdata_half};
            F3_W:    o_rdata = i_rdata_word;
            default: o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: request decode, alignment check, single-cycle memory
// access and a valid/ready response channel back to writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic [1:0]      resp_err,
    output logic            mem_memwrite,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_load_type,
    output logic [1:0]      mem_store_type,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata_word,
    input  logic [15:0]     mem_rdata_half,
    input  logic [7:0]      mem_rdata_byte
);

    lsu_state_e      r_state, w_next_state;
    logic            r_req_ready;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    mem_size_e       r_mem_size;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_rdata;
    logic [4:0]      r_resp_rd;
    lsu_err_e        r_resp_err;

    logic            w_accept;
    mem_size_e       w_size;
    lsu_err_e        w_err;
    logic [31:0]     w_ext;

    assign w_accept = req_valid & r_req_ready;
    assign w_size   = f3_size(req_funct3);
    // Illegal funct3 outranks misalignment
    assign w_err    = !f3_legal(req_we, req_funct3) ? ILLEGAL :
                      (f3_misaligned(w_size, req_addr[1:0]) ? MISALIGN : OK);

    lsu_extend u_extend (
        .i_funct3     (r_funct3),
        .i_rdata_word (mem_rdata_word),
        .i_rdata_half (mem_rdata_half),
        .i_rdata_byte (mem_rdata_byte),
        .o_rdata      (w_ext)
    );

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err == OK) w_next_state = ACCESS;
                    else             w_next_state = RESP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP: begin
                if (resp_ready) w_next_state = IDLE;
                else            w_next_state = RESP;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register; ready is registered so it reads 0 while in reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == IDLE);
        end
    end

    // Request capture; memory-side outputs only move for a real access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_size  <= WORD;
            r_mem_wdata <= '0;
        end else if (w_accept && (w_err == OK)) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_rd        <= req_rd;
            r_mem_we    <= req_we;
            r_mem_addr  <= req_addr;
            r_mem_size  <= w_size;
            r_mem_wdata <= req_wdata;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    // Response channel: errors load straight from IDLE, accesses at end of ACCESS
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= OK;
        end else if ((r_state == IDLE) && w_accept && (w_err != OK)) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= w_err;
        end else if (r_state == ACCESS) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? '0 : w_ext;
            r_resp_rd    <= r_we ? 5'd0 : r_rd;
            r_resp_err   <= OK;
        end else if ((r_state == RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= r_resp_valid;
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_rd        = r_resp_rd;
    assign resp_err       = r_resp_err;
    assign mem_memwrite   = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_load_type  = r_mem_size;
    assign mem_store_type = r_mem_size;
    assign mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressed memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        req_ready, resp_valid, mem_memwrite;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata_word;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err, mem_load_type, mem_store_type;
    logic [15:0] mem_rdata_half;
    logic [7:0]  mem_rdata_byte;

    logic [7:0]  mem [0:15];
    logic [3:0]  w_wb, w_hb;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
        .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .mem_wdata(mem_wdata), .mem_rdata_word(mem_rdata_word),
        .mem_rdata_half(mem_rdata_half), .mem_rdata_byte(mem_rdata_byte)
    );

    assign w_wb = {mem_addr[3:2], 2'b00};
    assign w_hb = {mem_addr[3:1], 1'b0};
    assign mem_rdata_word = {mem[w_wb + 4'd3], mem[w_wb + 4'd2], mem[w_wb + 4'd1], mem[w_wb]};
    assign mem_rdata_half = {mem[w_hb + 4'd1], mem[w_hb]};
    assign mem_rdata_byte = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_memwrite) begin
            case (mem_store_type)
                2'b00: begin
                    mem[w_wb]        <= mem_wdata[7:0];
                    mem[w_wb + 4'd1] <= mem_wdata[15:8];
                    mem[w_wb + 4'd2] <= mem_wdata[23:16];
                    mem[w_wb + 4'd3] <= mem_wdata[31:24];
                end
                2'b01: begin
                    mem[w_hb]        <= mem_wdata[7:0];
                    mem[w_hb + 4'd1] <= mem_wdata[15:8];
                end
                default: mem[mem_addr[3:0]] <= mem_wdata[7:0];
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [4:0]  erd;
        int          lat;
        int          wr;
        logic [1:0]  size;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input logic [1:0] err,
                                input logic [31:0] rdata, input logic [4:0] erd, input int lat,
                                input int wr, input logic [1:0] size);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.err = err;
        v.rdata = rdata; v.erd = erd; v.lat = lat; v.wr = wr; v.size = size;
        return v;
    endfunction

    function automatic logic [31:0] memword(input int b);
        return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int guard, lat, wcnt;
        logic [1:0] st_seen;
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; wcnt = 0; st_seen = 2'b11;
        while (!resp_valid && lat < 8) begin
            if (mem_memwrite) begin wcnt++; st_seen = mem_store_type; end
            @(posedge clk); #1; lat++;
        end
        if (mem_memwrite) wcnt++;
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_memwrite_cycles", idx), wcnt, v.wr);
        chk($sformatf("v%0d_err", idx), {30'd0, resp_err}, {30'd0, v.err});
        chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d_rd", idx), {27'd0, resp_rd}, {27'd0, v.erd});
        if (v.wr == 1) chk($sformatf("v%0d_store_type", idx), {30'd0, st_seen}, {30'd0, v.size});
        if (v.err == 2'b00 && !v.we) chk($sformatf("v%0d_load_type", idx), {30'd0, mem_load_type}, {30'd0, v.size});
        @(posedge clk); #1;
        chk($sformatf("v%0d_resp_drop", idx), {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        //           we    f3      addr         wdata          rd     err    rdata          erd   lat wr size
        vecs[0]  = mk(1'b1, F3_W,  32'h4, 32'hDEADBEEF, 5'd3,  2'b00, 32'h0,        5'd0,  2, 1, 2'b00);
        vecs[1]  = mk(1'b0, F3_W,  32'h4, 32'h0,        5'd5,  2'b00, 32'hDEADBEEF, 5'd5,  2, 0, 2'b00);
        vecs[2]  = mk(1'b0, F3_B,  32'h7, 32'h0,        5'd6,  2'b00, 32'hFFFFFFDE, 5'd6,  2, 0, 2'b10);
        vecs[3]  = mk(1'b0, F3_BU, 32'h7, 32'h0,        5'd7,  2'b00, 32'h000000DE, 5'd7,  2, 0, 2'b10);
        vecs[4]  = mk(1'b0, F3_H,  32'h6, 32'h0,        5'd8,  2'b00, 32'hFFFFDEAD, 5'd8,  2, 0, 2'b01);
        vecs[5]  = mk(1'b0, F3_HU, 32'h6, 32'h0,        5'd9,  2'b00, 32'h0000DEAD, 5'd9,  2, 0, 2'b01);
        vecs[6]  = mk(1'b1, F3_H,  32'h6, 32'h1234ABCD, 5'd4,  2'b00, 32'h0,        5'd0,  2, 1, 2'b01);
        vecs[7]  = mk(1'b0, F3_W,  32'h4, 32'h0,        5'd10, 2'b00, 32'hABCDBEEF, 5'd10, 2, 0, 2'b00);
        vecs[8]  = mk(1'b1, F3_B,  32'h7, 32'h000000EF, 5'd2,  2'b00, 32'h0,        5'd0,  2, 1, 2'b10);
        vecs[9]  = mk(1'b0, F3_W,  32'h4, 32'h0,        5'd11, 2'b00, 32'hEFCDBEEF, 5'd11, 2, 0, 2'b00);
        vecs[10] = mk(1'b0, F3_H,  32'h5, 32'h0,        5'd12, 2'b01, 32'h0,        5'd0,  1, 0, 2'b01);
        vecs[11] = mk(1'b1, F3_W,  32'h6, 32'h11111111, 5'd13, 2'b01, 32'h0,        5'd0,  1, 0, 2'b00);
        vecs[12] = mk(1'b0, 3'b011, 32'h4, 32'h0,       5'd14, 2'b10, 32'h0,        5'd0,  1, 0, 2'b00);
        vecs[13] = mk(1'b1, F3_BU, 32'h4, 32'h22222222, 5'd15, 2'b10, 32'h0,        5'd0,  1, 0, 2'b00);
        vecs[14] = mk(1'b0, 3'b110, 32'h5, 32'h0,       5'd16, 2'b10, 32'h0,        5'd0,  1, 0, 2'b00);
        vecs[15] = mk(1'b0, F3_W,  32'h3, 32'h0,        5'd17, 2'b01, 32'h0,        5'd0,  1, 0, 2'b00);
        vecs[16] = mk(1'b0, F3_W,  32'h4, 32'h0,        5'd18, 2'b00, 32'hEFCDBEEF, 5'd18, 2, 0, 2'b00);

        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Backpressure: response held for 3 cycles while a new request waits
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h4; req_rd = 5'd12;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h55555555;
        @(posedge clk); #1;
        chk("bp_valid", {31'd0, resp_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d_rdata", c), resp_rdata, 32'hEFCDBEEF);
            chk($sformatf("bp%0d_rd", c), {27'd0, resp_rd}, 32'd12);
            chk($sformatf("bp%0d_err", c), {30'd0, resp_err}, 32'd0);
            chk($sformatf("bp%0d_req_ready", c), {31'd0, req_ready}, 32'd0);
            chk($sformatf("bp%0d_memwrite", c), {31'd0, mem_memwrite}, 32'd0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop", {31'd0, resp_valid}, 32'd0);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_mem0_untouched", memword(0), 32'h0);

        // Reset during ACCESS of a store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h8;
        req_wdata = 32'h11223344; req_rd = 5'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ra_memwrite_high", {31'd0, mem_memwrite}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ra_memwrite_drop", {31'd0, mem_memwrite}, 32'd0);
        chk("ra_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("ra_req_ready", {31'd0, req_ready}, 32'd1);
        chk("ra_resp_valid_after", {31'd0, resp_valid}, 32'd0);
        chk("ra_mem8_untouched", memword(8), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
